// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle RV32 datapath: owns the PC, fetches over req/ack and presents one instruction per EXEC cycle.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCsrc,
  input  logic [31:0] imm,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] I,
  output logic        I_valid,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [1:0]  dbg_state   // 0=BOOT, 1=REQ, 2=EXEC
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // The 5-bit wait counter bounds the usable timeout range.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 2..32");
  end

  state_t      state;
  logic [31:0] pc_sum;
  logic [31:0] next_pc;

  always_comb begin
    pc_sum  = PCsrc ? (pc + imm) : (pc + 32'd4);
    next_pc = {pc_sum[31:2], 2'b00};
  end

  assign imem_addr = pc;
  assign dbg_state = state;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT_CYC - 1);
  logic [4:0] wait_cnt;
  logic       timed_out;
  assign timed_out = (wait_cnt == WAIT_LAST);
`else
  assign fetch_err = 1'b0;
`endif

  // Handshake: imem_req is held high with a stable imem_addr for the whole REQ
  // state; the fetch completes on the first rising edge that sees imem_ack=1,
  // with imem_rdata valid in that same cycle. imem_ack is ignored elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      I        <= NOP;
      I_valid  <= 1'b0;
      imem_req <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_BOOT: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_REQ: begin
          if (imem_ack) begin
            I        <= imem_rdata;
            I_valid  <= 1'b1;
            imem_req <= 1'b0;
            state    <= ST_EXEC;
`ifdef FETCH_TIMEOUT_EN
          end else if (timed_out) begin
            // Abandon the fetch and retire a NOP in its place.
            I         <= NOP;
            I_valid   <= 1'b1;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ST_EXEC;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
`endif
          end
        end
        ST_EXEC: begin
          // Stall takes priority: PCsrc/imm only matter on the releasing edge.
          if (!stall) begin
            pc       <= next_pc;
            I_valid  <= 1'b0;
            imem_req <= 1'b1;
            state    <= ST_REQ;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        default: begin
          state    <= ST_BOOT;
          I_valid  <= 1'b0;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
